// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-bit iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle for 32 cycles,
// followed by a two-cycle finish (sign correction, then HI/LO write-back).
// Start-to-done latency is 34 cycles.
// Optional feature: define MULDIV_DIV_EN to include the divide datapath
// (DIV/DIVU). Without it, starts with op[1]=1 are ignored.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting; MTHI/MTLO writes accepted, start latches operands
  // CALC  | 32 iterative multiply/divide steps, one per cycle
  // FIN   | phase 0: sign correction in acc; phase 1: write HI/LO, pulse done
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        fin_ph_q, fin_ph_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand preparation: signed ops (op[0]=0) work on magnitudes
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        start_ok;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? (~a + 32'd1) : a;
  assign b_mag     = b_neg ? (~b + 32'd1) : b;

`ifdef MULDIV_DIV_EN
  assign start_ok = start;
`else
  assign start_ok = start & ~op[1];
`endif

  // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB, shift right
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, ma_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Sign-corrected multiply result
  logic [63:0] mul_fix;
  assign mul_fix = ((op_q == 2'b00) && (sa_q ^ sb_q)) ? (~acc_q + 64'd1) : acc_q;

`ifdef MULDIV_DIV_EN
  // Divide step: acc = {remainder, quotient}; shift left, try subtracting divisor.
  // rem_sh can exceed 32 bits only when it is already larger than any divisor.
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, mb_q};
  assign div_next = div_diff[33] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  // Divide sign correction; divide-by-zero returns the original dividend in HI
  logic [31:0] quo_fix, rem_fix, dvd_raw;
  logic [63:0] div_fix;

  assign dvd_raw = sa_q ? (~ma_q + 32'd1) : ma_q;
  assign quo_fix = (~op_q[0] & (sa_q ^ sb_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix = (~op_q[0] & sa_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  assign div_fix = (mb_q == 32'd0) ? {dvd_raw, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
`endif

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_ph_d = fin_ph_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          op_d     = op;
          sa_d     = a_neg;
          sb_d     = b_neg;
          ma_d     = a_mag;
          mb_d     = b_mag;
          acc_d    = op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          cnt_d    = 5'd0;
          fin_ph_d = 1'b0;
          state_d  = S_CALC;
        end else begin
          if (hi_we) hi_d = a;
          if (lo_we) lo_d = a;
        end
      end

      S_CALC: begin
`ifdef MULDIV_DIV_EN
        acc_d = op_q[1] ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_FIN;
          fin_ph_d = 1'b0;
        end
      end

      S_FIN: begin
        if (!fin_ph_q) begin
`ifdef MULDIV_DIV_EN
          acc_d = op_q[1] ? div_fix : mul_fix;
`else
          acc_d = mul_fix;
`endif
          fin_ph_d = 1'b1;
        end else begin
          hi_d     = acc_q[63:32];
          lo_d     = acc_q[31:0];
          done_d   = 1'b1;
          fin_ph_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset clearing everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      fin_ph_q <= 1'b0;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fin_ph_q <= fin_ph_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
